// File: rtl/i2c_slave_if.sv
// Pin-level and byte-level signals of the I2C target, as seen from the bus
// master/bench side and from the target itself.
interface i2c_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic [3:0] state;

  modport slave (
    input  scl_in, sda_in, rx_ready, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, busy, state
  );

  modport master (
    output scl_in, sda_in, rx_ready, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, busy, state
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, write
// bytes out on rx_*, read bytes fetched through tx_req/tx_data.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       resetN,
  i2c_slave_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    ADDRESS    = 4'd1,
    ADDR_ACK   = 4'd2,
    WRITE_DATA = 4'd3,
    WRITE_ACK  = 4'd4,
    READ_DATA  = 4'd5,
    READ_ACK   = 4'd6,
    WAIT_STOP  = 4'd7
  } state_t;

  state_t     state_reg;
  logic       scl_m, scl_s, scl_q;
  logic       sda_m, sda_s, sda_q;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [6:0] tx_shift_reg;
  logic       rw_reg, ready_reg, done_reg, mack_reg;
  logic       sda_oe_reg, rx_valid_reg, busy_reg;
  logic [7:0] rx_data_reg;

  logic scl_rise, scl_fall, start_det, stop_det, tx_req;

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  // Decoded from flops so tx_data is captured in the very cycle tx_req is high.
  assign tx_req = ~start_det & ~stop_det & scl_fall &
                  (((state_reg == ADDR_ACK) & rw_reg) |
                   ((state_reg == READ_ACK) & done_reg & ~mack_reg));

  always_ff @(posedge clk) begin
    if (!resetN) begin
      {scl_m, scl_s, scl_q} <= 3'b111;
      {sda_m, sda_s, sda_q} <= 3'b111;
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd7;
      shift_reg    <= 8'h00;
      tx_shift_reg <= 7'h00;
      rw_reg       <= 1'b0;
      ready_reg    <= 1'b0;
      done_reg     <= 1'b0;
      mack_reg     <= 1'b1;
      sda_oe_reg   <= 1'b0;
      rx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      rx_data_reg  <= 8'h00;
    end else begin
      scl_m <= bus.scl_in;
      scl_s <= scl_m;
      scl_q <= scl_s;
      sda_m <= bus.sda_in;
      sda_s <= sda_m;
      sda_q <= sda_s;
      rx_valid_reg <= 1'b0;

      if (start_det) begin
        state_reg   <= ADDRESS;
        bit_cnt_reg <= 3'd7;
        shift_reg   <= 8'h00;
        done_reg    <= 1'b0;
        sda_oe_reg  <= 1'b0;
        busy_reg    <= 1'b1;
      end else if (stop_det) begin
        state_reg  <= IDLE;
        done_reg   <= 1'b0;
        sda_oe_reg <= 1'b0;
        busy_reg   <= 1'b0;
      end else if (tx_req) begin
        tx_shift_reg <= bus.tx_data[6:0];
        sda_oe_reg   <= ~bus.tx_data[7];
        bit_cnt_reg  <= 3'd7;
        done_reg     <= 1'b0;
        state_reg    <= READ_DATA;
      end else begin
        case (state_reg)
          ADDRESS: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_s};
              if (bit_cnt_reg == 3'd0) done_reg <= 1'b1;
              else                     bit_cnt_reg <= bit_cnt_reg - 3'd1;
            end else if (scl_fall && done_reg) begin
              done_reg <= 1'b0;
              rw_reg   <= shift_reg[0];
              if (shift_reg[7:1] == SLAVE_ADDR) begin
                sda_oe_reg <= 1'b1;
                state_reg  <= ADDR_ACK;
              end else begin
                sda_oe_reg <= 1'b0;
                state_reg  <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            // Read direction leaves this state through the tx_req branch.
            if (scl_fall) begin
              sda_oe_reg  <= 1'b0;
              bit_cnt_reg <= 3'd7;
              state_reg   <= WRITE_DATA;
            end
          end
          WRITE_DATA: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_s};
              if (bit_cnt_reg == 3'd0) begin
                rx_data_reg  <= {shift_reg[6:0], sda_s};
                rx_valid_reg <= 1'b1;
                ready_reg    <= bus.rx_ready;
                done_reg     <= 1'b1;
              end else begin
                bit_cnt_reg <= bit_cnt_reg - 3'd1;
              end
            end else if (scl_fall && done_reg) begin
              done_reg   <= 1'b0;
              sda_oe_reg <= ready_reg;
              state_reg  <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe_reg  <= 1'b0;
              bit_cnt_reg <= 3'd7;
              state_reg   <= ready_reg ? WRITE_DATA : WAIT_STOP;
            end
          end
          READ_DATA: begin
            if (scl_fall) begin
              if (bit_cnt_reg == 3'd0) begin
                sda_oe_reg <= 1'b0;
                done_reg   <= 1'b0;
                state_reg  <= READ_ACK;
              end else begin
                sda_oe_reg   <= ~tx_shift_reg[6];
                tx_shift_reg <= {tx_shift_reg[5:0], 1'b0};
                bit_cnt_reg  <= bit_cnt_reg - 3'd1;
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              mack_reg <= sda_s;
              done_reg <= 1'b1;
            end else if (scl_fall && done_reg && mack_reg) begin
              done_reg   <= 1'b0;
              sda_oe_reg <= 1'b0;
              state_reg  <= WAIT_STOP;
            end
          end
          IDLE, WAIT_STOP: sda_oe_reg <= 1'b0;
          default: begin
            sda_oe_reg <= 1'b0;
            state_reg  <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe   = sda_oe_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.tx_req   = tx_req;
  assign bus.busy     = busy_reg;
  assign bus.state    = state_reg;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master plus a scoreboard of expected
// write bytes that is drained whenever the target pulses rx_valid.
module tb_i2c_slave;
  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic resetN;
  logic m_scl, m_sda;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   tx_cnt   = 0;
  logic oe_seen  = 1'b0;
  logic prev_rx_valid = 1'b0;
  logic prev_tx_req   = 1'b0;
  logic [7:0] rx_q[$];

  i2c_slave_if bus ();

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND of master and target.
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_bit(input logic b, output logic r);
    m_sda = b;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    r = bus.sda_in;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    m_sda = 1'b1;
    tick(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) do_bit(b[i], r);
    do_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      do_bit(1'b1, r);
      d = {d[6:0], r};
    end
    do_bit(mack, r);
  endtask

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      if (rx_q.size() == 0) check_eq("rx_unexpected", 32'd1, 32'd0);
      else                  check_eq("rx_data", {24'd0, bus.rx_data}, {24'd0, rx_q.pop_front()});
      if (prev_rx_valid) check_eq("rx_valid_width", 32'd2, 32'd1);
    end
    if (bus.tx_req) begin
      tx_cnt++;
      if (prev_tx_req) check_eq("tx_req_width", 32'd2, 32'd1);
    end
    if (bus.rx_valid && bus.tx_req) check_eq("rx_tx_overlap", 32'd1, 32'd0);
    if (bus.sda_oe) oe_seen = 1'b1;
    prev_rx_valid = bus.rx_valid;
    prev_tx_req   = bus.tx_req;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic       r;
    int         tx0;

    resetN = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    bus.rx_ready = 1'b1;
    bus.tx_data  = 8'h00;
    tick(3);
    check_eq("rst_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_state", {28'd0, bus.state}, 32'd0);
    check_eq("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    resetN = 1'b1;
    tick(3);

    // Two-byte write with the sink ready.
    i2c_start();
    write_byte(8'hA0, ack);
    check_eq("w_addr_ack", {31'd0, ack}, 32'd0);
    check_eq("w_busy", {31'd0, bus.busy}, 32'd1);
    rx_q.push_back(8'hA5);
    write_byte(8'hA5, ack);
    check_eq("w_data1_ack", {31'd0, ack}, 32'd0);
    rx_q.push_back(8'h3C);
    write_byte(8'h3C, ack);
    check_eq("w_data2_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    check_eq("w_busy_after_stop", {31'd0, bus.busy}, 32'd0);
    check_eq("w_state_idle", {28'd0, bus.state}, 32'd0);
    check_eq("w_rx_data_last", {24'd0, bus.rx_data}, 32'h3C);

    // Wrong address: never driven, no bytes delivered.
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack);
    check_eq("badaddr_nack", {31'd0, ack}, 32'd1);
    check_eq("badaddr_state", {28'd0, bus.state}, 32'd7);
    write_byte(8'h55, ack);
    check_eq("badaddr_data_nack", {31'd0, ack}, 32'd1);
    check_eq("badaddr_oe_seen", {31'd0, oe_seen}, 32'd0);
    i2c_stop();
    check_eq("badaddr_state_idle", {28'd0, bus.state}, 32'd0);

    // Two-byte read, master NACKs the second.
    tx0 = tx_cnt;
    bus.tx_data = 8'h96;
    i2c_start();
    write_byte(8'hA1, ack);
    check_eq("r_addr_ack", {31'd0, ack}, 32'd0);
    bus.tx_data = 8'h0F;
    read_byte(1'b0, d);
    check_eq("r_byte1", {24'd0, d}, 32'h96);
    read_byte(1'b1, d);
    check_eq("r_byte2", {24'd0, d}, 32'h0F);
    tick(2);
    check_eq("r_oe_after_nack", {31'd0, bus.sda_oe}, 32'd0);
    check_eq("r_state_wait", {28'd0, bus.state}, 32'd7);
    check_eq("r_tx_req_count", tx_cnt - tx0, 32'd2);
    i2c_stop();

    // Write refused by the sink: byte still delivered, then NACK and ignore.
    bus.rx_ready = 1'b0;
    i2c_start();
    write_byte(8'hA0, ack);
    check_eq("nr_addr_ack", {31'd0, ack}, 32'd0);
    rx_q.push_back(8'h77);
    write_byte(8'h77, ack);
    check_eq("nr_data_nack", {31'd0, ack}, 32'd1);
    check_eq("nr_state_wait", {28'd0, bus.state}, 32'd7);
    write_byte(8'h12, ack);
    check_eq("nr_ignored_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    bus.rx_ready = 1'b1;

    // Repeated START mid-byte drops the partial byte; read follows.
    tx0 = tx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check_eq("rs_addr_ack", {31'd0, ack}, 32'd0);
    do_bit(1'b1, r);
    do_bit(1'b0, r);
    do_bit(1'b1, r);
    do_bit(1'b1, r);
    bus.tx_data = 8'hC3;
    i2c_start();
    write_byte(8'hA1, ack);
    check_eq("rs_read_ack", {31'd0, ack}, 32'd0);
    read_byte(1'b1, d);
    check_eq("rs_read_byte", {24'd0, d}, 32'hC3);
    check_eq("rs_tx_req_count", tx_cnt - tx0, 32'd1);
    i2c_stop();

    // Reset while acknowledging the address.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'hA0;
      do_bit(a[i], r);
    end
    check_eq("ra_oe_before", {31'd0, bus.sda_oe}, 32'd1);
    check_eq("ra_state_before", {28'd0, bus.state}, 32'd2);
    resetN = 1'b0;
    tick(1);
    resetN = 1'b1;
    check_eq("ra_oe_after", {31'd0, bus.sda_oe}, 32'd0);
    check_eq("ra_state_after", {28'd0, bus.state}, 32'd0);
    check_eq("ra_busy_after", {31'd0, bus.busy}, 32'd0);
    check_eq("ra_rx_data_after", {24'd0, bus.rx_data}, 32'd0);
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(2 * Q);

    check_eq("rx_queue_drained", rx_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
